// File: rtl/baccarat_dealer.sv
`default_nettype none
// ============================================================================
// Module   : baccarat_dealer
// Purpose  : Sequencing stage of the baccarat engine. Deals cards into the
//            player and dealer hand registers one step at a time, applies
//            the third-card drawing rules and declares the winner from the
//            totals reported back by the external hand scorers.
// Ports    : slow_clock        - sole clock, rising edge
//            resetb            - asynchronous active-low reset
//            step              - advance qualifier (FSM acts only when 1)
//            new_card[3:0]     - card code from the generator
//            pscore/dscore     - player/dealer totals 0-9 from the scorers
//            pcard1..3/dcard1..3 - registered hand cards (0 = blank)
//            player_win/dealer_win - registered result (both high = tie)
//            done              - registered round-complete flag
// Revision : 1.0 - initial release
// ============================================================================
module baccarat_dealer (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       step,
  input  logic [3:0] new_card,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done
);

  typedef enum logic [2:0] {
    S_P1    = 3'd0,
    S_D1    = 3'd1,
    S_P2    = 3'd2,
    S_D2    = 3'd3,
    S_NAT   = 3'd4,
    S_BANK  = 3'd5,
    S_SCORE = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       load_p1, load_d1, load_p2, load_d2, load_p3, load_d3;
  logic       latch_result;
  logic [3:0] p3_value;
  logic       bank_draws;

  // Face cards, tens and out-of-range codes count as zero in the table.
  always_comb begin
    p3_value = 4'd0;
    if (pcard3 >= 4'd1 && pcard3 <= 4'd9) p3_value = pcard3;
  end

  // Dealer third-card table, used only after the player has drawn.
  always_comb begin
    bank_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: bank_draws = 1'b1;
      4'd3:             bank_draws = (p3_value != 4'd8);
      4'd4:             bank_draws = (p3_value >= 4'd2) && (p3_value <= 4'd7);
      4'd5:             bank_draws = (p3_value >= 4'd4) && (p3_value <= 4'd7);
      4'd6:             bank_draws = (p3_value >= 4'd6) && (p3_value <= 4'd7);
      default:          bank_draws = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state <= S_P1;
    else         state <= next_state;
  end

  always_comb begin
    next_state   = state;
    load_p1      = 1'b0;
    load_d1      = 1'b0;
    load_p2      = 1'b0;
    load_d2      = 1'b0;
    load_p3      = 1'b0;
    load_d3      = 1'b0;
    latch_result = 1'b0;
    if (step) begin
      case (state)
        S_P1: begin load_p1 = 1'b1; next_state = S_D1; end
        S_D1: begin load_d1 = 1'b1; next_state = S_P2; end
        S_P2: begin load_p2 = 1'b1; next_state = S_D2; end
        S_D2: begin load_d2 = 1'b1; next_state = S_NAT; end
        S_NAT: begin
          // Third cards are still blank here, so the scores are two-card totals.
          if (pscore >= 4'd8 || dscore >= 4'd8) begin
            next_state = S_SCORE;
          end else if (pscore <= 4'd5) begin
            load_p3    = 1'b1;
            next_state = S_BANK;
          end else begin
            load_d3    = (dscore <= 4'd5);
            next_state = S_SCORE;
          end
        end
        S_BANK: begin
          load_d3    = bank_draws;
          next_state = S_SCORE;
        end
        S_SCORE: begin
          latch_result = 1'b1;
          next_state   = S_DONE;
        end
        S_DONE: next_state = S_DONE;
        default: next_state = S_P1;
      endcase
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      pcard1     <= 4'd0;
      pcard2     <= 4'd0;
      pcard3     <= 4'd0;
      dcard1     <= 4'd0;
      dcard2     <= 4'd0;
      dcard3     <= 4'd0;
      player_win <= 1'b0;
      dealer_win <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (load_p1) pcard1 <= new_card;
      if (load_d1) dcard1 <= new_card;
      if (load_p2) pcard2 <= new_card;
      if (load_d2) dcard2 <= new_card;
      if (load_p3) pcard3 <= new_card;
      if (load_d3) dcard3 <= new_card;
      if (latch_result) begin
        player_win <= (pscore >= dscore);
        dealer_win <= (dscore >= pscore);
        done       <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/baccarat_dealer.md
# baccarat_dealer

Sequencing stage of the baccarat engine: it deals cards into the player and dealer hand registers one step at a time and applies the third-card drawing rules. It declares the winner from the scores of the two downstream hand-scoring instances, which feed their totals back to it. Card codes come from the upstream card generator; the six registered card outputs drive the scorers and the display.

## Interface
Parameters: none.

- slow_clock  input  1  sole clock; all state changes on rising edge.
- resetb  input  1  reset, asynchronous and active-low.
- step  input  1  advance qualifier; the FSM acts only on edges where step=1.
- new_card  input  4  card code from the generator: 1=ace, 2–9 pips, 10=ten, 11=J, 12=Q, 13=K.
- pscore  input  4  player total 0–9 from the external scorer fed by pcard1..3 (combinational).
- dscore  input  4  dealer total 0–9 from the external scorer fed by dcard1..3 (combinational).
- pcard1, pcard2, pcard3  output  4 each  registered player cards; 0 = blank.
- dcard1, dcard2, dcard3  output  4 each  registered dealer cards; 0 = blank.
- player_win  output  1  registered; valid when done=1.
- dealer_win  output  1  registered; valid when done=1. Both high means a tie.
- done  output  1  registered; the round is complete.

## Operation
- Reset (async, resetb=0): all six cards become 4'b0000, player_win=0, dealer_win=0, done=0, state=S_P1. Reset takes effect with no clock edge, including mid-round.
- States: S_P1, S_D1, S_P2, S_D2, S_NAT, S_BANK, S_SCORE, S_DONE. With step=0, the state and all outputs hold.
- S_P1/S_D1/S_P2/S_D2: load new_card into pcard1/dcard1/pcard2/dcard2 respectively, then go to the next state in that order.
- S_NAT (pscore/dscore reflect two cards each, since third cards are blank):
  - If pscore≥8 or dscore≥8: natural. Load nothing; go to S_SCORE.
  - Else if pscore≤5: load new_card into pcard3; go to S_BANK.
  - Else (player stands on 6–7): if dscore≤5, load new_card into dcard3. Go to S_SCORE.
- S_BANK: let v = value of pcard3, where codes 1–9 map to 1–9 and all other codes map to 0. The dealer draws (loads new_card into dcard3) when:
  - dscore 0–2: always.
  - dscore 3: v≠8.
  - dscore 4: v in 2–7.
  - dscore 5: v in 4–7.
  - dscore 6: v in 6–7.
  - dscore 7: never.
  - Go to S_SCORE in every case.
- S_SCORE: latch player_win=(pscore>dscore)|(pscore==dscore) and dealer_win=(dscore>pscore)|(pscore==dscore). Set done=1 and go to S_DONE.
- S_DONE: all outputs frozen until reset; step is ignored.
- new_card codes 0, 14 and 15 are loaded as-is; the scorers treat them as value 0.
- Comparisons are 4-bit unsigned. pscore/dscore inputs above 9 are not produced by the scorers and need no handling.

## Timing
- One action per step-qualified edge; a card output changes on the edge that loads it.
- Scores are sampled in the state after the card load, so no same-edge dependency exists between a card register and the score it produces.
- Round length: 6 steps when no player third card is dealt (4 deals, S_NAT, S_SCORE), 7 steps when the player draws (adds S_BANK).
- done, player_win and dealer_win rise on the same edge, the final step edge, and stay high until reset.
- step held high continuously advances one state per clock.

## Test plan
- Natural: deal P=4, D=2, P=4, D=3 (p=8, d=5), then 2 more steps. Required: no third cards, done=1 after step 6, player_win=1, dealer_win=0.
- Player stands, dealer draws: P=3, D=2, P=3, D=2 (p=6, d=4); S_NAT card=7. Required: pcard3=0, dcard3=7 (d=1), done after step 6, player_win=1.
- Table draw: P=2, D=3, P=1, D=3 (p=3, d=6); S_NAT card=6 (p=9); S_BANK card=1. Required: dcard3=1 (d=7), done after step 7, player_win=1, dealer_win=0.
- Table stand on face card: P=1, D=4, P=1, D=2 (p=2, d=6); S_NAT card=13 (v=0, p=2). Required: dcard3 stays 0, dealer_win=1, player_win=0.
- Tie: P=10, D=12, P=11, D=13 (p=0, d=0); S_NAT card=5; S_BANK card=5. Required: pcard3=5, dcard3=5, player_win=1, dealer_win=1.
- Holds and reset:
  - step=0 for 5 clocks in S_D1: no output changes.
  - Drop resetb between edges after S_P2: all cards read 0 and done=0 immediately.
  - After release, the next step loads pcard1.
